sub_share_arbiter: RTL
======================

// Module: sub_share_arbiter
// PURPOSE
//  Shares one external sub_32bit_signed instance among NUM_REQ requesters.
//  Round-robin arbitration over valid/ready request channels; sequences operands
//  into the subtractor, registers result+overflow, returns them on a single
//  valid/ready response channel tagged with requester id.
//  Keeps a per-requester sticky overflow status.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  WIDTH    32  operand width; must match the attached subtractor
//  IDW      2   id width, = clog2(NUM_REQ)
// PORTS
//  clk           in   1              clock, rising edge
//  rst_n         in   1              synchronous active-low reset
//  req_valid     in   NUM_REQ        per-requester request valid
//  req_ready     out  NUM_REQ        per-requester accept (one-hot or zero)
//  req_a         in   NUM_REQ*WIDTH  minuend, requester i at [i*WIDTH +: WIDTH]
//  req_b         in   NUM_REQ*WIDTH  subtrahend, same packing
//  sub_a         out  WIDTH          to subtractor A
//  sub_b         out  WIDTH          to subtractor B
//  sub_result    in   WIDTH          from subtractor result (combinational A-B)
//  sub_overflow  in   1              from subtractor overflow
//  rsp_valid     out  1              response valid
//  rsp_ready     in   1              response accept
//  rsp_id        out  IDW            requester index of response
//  rsp_result    out  WIDTH          signed A-B, two's complement wrap
//  rsp_overflow  out  1              signed overflow of that subtraction
//  ovf_sticky    out  NUM_REQ        set on accepted response with overflow
//  ovf_clr       in   NUM_REQ        per-bit clear of ovf_sticky
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, rr_ptr=0, all outputs 0, ovf_sticky=0.
//    Reset mid-transaction discards it; no response is ever produced.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE. No request accepted outside IDLE.
//  - IDLE: grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ...
//    mod NUM_REQ. req_ready[g]=1 combinationally in that same cycle only; on the
//    edge latch op_a/op_b from slot g, grant id=g, go ISSUE. None valid: stay.
//  - ISSUE: sub_a/sub_b = op_a/op_b (held stable from ISSUE through RESP,
//    0 in IDLE). On the edge capture sub_result/sub_overflow into rsp regs, go RESP.
//  - RESP: rsp_valid=1; rsp_id/result/overflow stable while rsp_ready=0.
//    On rsp_valid&&rsp_ready: go IDLE, rr_ptr = (id+1) mod NUM_REQ,
//    set ovf_sticky[id] if rsp_overflow.
//  - Latency: handshake at cycle N -> rsp_valid high in cycle N+2.
//    Minimum 3 cycles per operation; no back-to-back accept in RESP.
//  - ovf_sticky: set and ovf_clr same cycle, same bit -> set wins.
//  - Requester deasserting req_valid without handshake is legal; not granted.
//  - rsp_ready ignored when rsp_valid=0. rr_ptr only advances on response accept.
// TESTING
//  1 req_valid[0], A=5,B=7 -> rsp_id=0, rsp_result=-2, rsp_overflow=0,
//    rsp_valid exactly 2 cycles after req_ready[0].
//  2 req1 A=-2147483648,B=1 -> result 2147483647, ovf=1, ovf_sticky=4'b0010;
//    ovf_clr[1] pulse -> ovf_sticky=0.
//  3 req2 A=2147483647,B=-1 -> result -2147483648, ovf=1; ovf_clr[2] asserted
//    in accept cycle -> ovf_sticky[2]=1 (set wins).
//  4 all 4 req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0,1; one
//    req_ready bit at a time, only in IDLE.
//  5 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout,
//    single response delivered when rsp_ready rises.
//  6 rst_n=0 one cycle during ISSUE -> rsp_valid never asserts for that op;
//    next request with all valid granted to requester 0.

Source files
------------

// File: rtl/sub_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sub_share_arbiter
// Brief   : Round-robin sharing of one external signed subtractor among
//           NUM_REQ valid/ready requesters, with a tagged response channel.
// Revision: 1.0
// ============================================================================
module sub_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         sub_a,
    output logic [WIDTH-1:0]         sub_b,
    input  logic [WIDTH-1:0]         sub_result,
    input  logic                     sub_overflow,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_overflow,
    output logic [NUM_REQ-1:0]       ovf_sticky,
    input  logic [NUM_REQ-1:0]       ovf_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 ovf_q, ovf_d;
    logic [NUM_REQ-1:0]   sticky_q, sticky_d;
    logic [NUM_REQ-1:0]   sticky_set;

    logic                 hi_found, lo_found, grant_found;
    logic [IDW-1:0]       hi_id, lo_id, grant_id;

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IDW'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_id    = IDW'(i);
                end
                lo_found = 1'b1;
                lo_id    = IDW'(i);
            end
        end
        grant_found = hi_found | lo_found;
        grant_id    = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        req_ready  = '0;
        sticky_set = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    id_d    = grant_id;
                    op_a_d  = req_a[int'(grant_id)*WIDTH +: WIDTH];
                    op_b_d  = req_b[int'(grant_id)*WIDTH +: WIDTH];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                res_d   = sub_result;
                ovf_d   = sub_overflow;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    sticky_set[id_q] = ovf_q;
                    rr_ptr_d = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A set in the same cycle as a clear of the same bit must survive.
        sticky_d = (sticky_q & ~ovf_clr) | sticky_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign sub_a        = (state_q == S_IDLE) ? '0 : op_a_q;
    assign sub_b        = (state_q == S_IDLE) ? '0 : op_b_q;
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_id       = id_q;
    assign rsp_result   = res_q;
    assign rsp_overflow = ovf_q;
    assign ovf_sticky   = sticky_q;

endmodule
`default_nettype wire
